// File: rtl/stage4_mem.sv
// stage4_mem: memory-access stage of the MIPS 16-bit pipeline.
// Captures instructions from EX, runs loads/stores over a req/ack data-memory
// handshake while stalling upstream, and drives the MEM/WB fields for stage5.
// Non-memory instructions pass through with one cycle of latency.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that receive no
// dm_ack within TIMEOUT ACCESS cycles (sets the sticky dm_err flag).
module stage4_mem #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       store_data,
  input  logic [4:0]        reg_dest4,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem2Reg_in,
  input  logic              reg_write_in,
  output logic              stall_out,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic [31:0]       mem_data,
  output logic [31:0]       alu_result,
  output logic              mem2Reg_ctrl,
  output logic [4:0]        reg_dest5,
  output logic              reg_write_wb,
  output logic              dm_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Request-side registers; the address is taken straight from the captured
  // ALU result so dm_addr stays stable for the whole access.
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] cap_alu_q, cap_alu_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic [4:0]  cap_dest_q, cap_dest_d;
  logic        cap_m2r_q, cap_m2r_d;
  logic        cap_rw_q, cap_rw_d;

  // MEM/WB register.
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic        mem2reg_q, mem2reg_d;
  logic [4:0]  reg_dest5_q, reg_dest5_d;
  logic        reg_write_wb_q, reg_write_wb_d;

  logic is_mem_op;
  logic accept_mem;
  logic timeout_hit;

  assign is_mem_op  = mem_read | mem_write;
  assign accept_mem = (state_q == IDLE) && ex_valid && is_mem_op;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dm_err_q, dm_err_d;

  // Abort on the last allowed ACCESS cycle; an ack on that same edge wins.
  assign timeout_hit = (state_q == ACCESS) && !dm_ack &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  // Wait counter cleared on ACCESS entry; error flag is sticky until reset.
  always_comb begin
    cnt_d    = cnt_q;
    dm_err_d = dm_err_q;
    if (accept_mem) begin
      cnt_d = '0;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (timeout_hit) begin
      dm_err_d = 1'b1;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dm_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dm_err_q <= dm_err_d;
    end
  end

  assign dm_err = dm_err_q;
`else
  assign timeout_hit = 1'b0;
  assign dm_err      = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: leave ACCESS on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ex_valid && is_mem_op) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (dm_ack || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output / datapath logic: capture, request control and MEM/WB loads.
  always_comb begin
    dm_req_d       = dm_req_q;
    dm_we_d        = dm_we_q;
    cap_alu_d      = cap_alu_q;
    cap_wdata_d    = cap_wdata_q;
    cap_dest_d     = cap_dest_q;
    cap_m2r_d      = cap_m2r_q;
    cap_rw_d       = cap_rw_q;
    wb_valid_d     = 1'b0;
    mem_data_d     = mem_data_q;
    alu_result_d   = alu_result_q;
    mem2reg_d      = mem2reg_q;
    reg_dest5_d    = reg_dest5_q;
    reg_write_wb_d = reg_write_wb_q;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (is_mem_op) begin
            cap_alu_d   = alu_result_in;
            cap_wdata_d = store_data;
            cap_dest_d  = reg_dest4;
            cap_m2r_d   = mem2Reg_in;
            // A store never writes the register file, even if mem_read is
            // also set (the store takes precedence).
            cap_rw_d    = reg_write_in & ~mem_write;
            dm_req_d    = 1'b1;
            dm_we_d     = mem_write;
          end else begin
            wb_valid_d     = 1'b1;
            mem_data_d     = '0;
            alu_result_d   = alu_result_in;
            mem2reg_d      = mem2Reg_in;
            reg_dest5_d    = reg_dest4;
            reg_write_wb_d = reg_write_in;
          end
        end
      end
      ACCESS: begin
        if (dm_ack) begin
          dm_req_d       = 1'b0;
          dm_we_d        = 1'b0;
          wb_valid_d     = 1'b1;
          mem_data_d     = dm_we_q ? 32'd0 : dm_rdata;
          alu_result_d   = cap_alu_q;
          mem2reg_d      = cap_m2r_q;
          reg_dest5_d    = cap_dest_q;
          reg_write_wb_d = cap_rw_q;
        end else if (timeout_hit) begin
          // Squashed retire: the slot advances but nothing is written back.
          dm_req_d       = 1'b0;
          dm_we_d        = 1'b0;
          wb_valid_d     = 1'b1;
          mem_data_d     = '0;
          alu_result_d   = cap_alu_q;
          mem2reg_d      = cap_m2r_q;
          reg_dest5_d    = cap_dest_q;
          reg_write_wb_d = 1'b0;
        end
      end
      default: begin
        dm_req_d = 1'b0;
        dm_we_d  = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops any in-flight request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req_q       <= 1'b0;
      dm_we_q        <= 1'b0;
      cap_alu_q      <= '0;
      cap_wdata_q    <= '0;
      cap_dest_q     <= '0;
      cap_m2r_q      <= 1'b0;
      cap_rw_q       <= 1'b0;
      wb_valid_q     <= 1'b0;
      mem_data_q     <= '0;
      alu_result_q   <= '0;
      mem2reg_q      <= 1'b0;
      reg_dest5_q    <= '0;
      reg_write_wb_q <= 1'b0;
    end else begin
      dm_req_q       <= dm_req_d;
      dm_we_q        <= dm_we_d;
      cap_alu_q      <= cap_alu_d;
      cap_wdata_q    <= cap_wdata_d;
      cap_dest_q     <= cap_dest_d;
      cap_m2r_q      <= cap_m2r_d;
      cap_rw_q       <= cap_rw_d;
      wb_valid_q     <= wb_valid_d;
      mem_data_q     <= mem_data_d;
      alu_result_q   <= alu_result_d;
      mem2reg_q      <= mem2reg_d;
      reg_dest5_q    <= reg_dest5_d;
      reg_write_wb_q <= reg_write_wb_d;
    end
  end

  assign stall_out    = (state_q == ACCESS);
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = cap_alu_q[ADDR_W-1:0];
  assign dm_wdata     = cap_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign mem_data     = mem_data_q;
  assign alu_result   = alu_result_q;
  assign mem2Reg_ctrl = mem2reg_q;
  assign reg_dest5    = reg_dest5_q;
  assign reg_write_wb = reg_write_wb_q;

endmodule

// File: tb/tb_stage4_mem.sv
// tb_stage4_mem: directed bench for stage4_mem with a retire scoreboard and
// a small data-memory responder. Timeout cases run when MEM_TIMEOUT_EN is set.
module tb_stage4_mem;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid;
  logic [31:0]       alu_result_in;
  logic [31:0]       store_data;
  logic [4:0]        reg_dest4;
  logic              mem_read;
  logic              mem_write;
  logic              mem2Reg_in;
  logic              reg_write_in;
  logic              stall_out;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;
  logic              wb_valid;
  logic [31:0]       mem_data;
  logic [31:0]       alu_result;
  logic              mem2Reg_ctrl;
  logic [4:0]        reg_dest5;
  logic              reg_write_wb;
  logic              dm_err;

  always #5 clk = ~clk;

  stage4_mem #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .alu_result_in(alu_result_in), .store_data(store_data),
    .reg_dest4(reg_dest4), .mem_read(mem_read), .mem_write(mem_write),
    .mem2Reg_in(mem2Reg_in), .reg_write_in(reg_write_in),
    .stall_out(stall_out), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .wb_valid(wb_valid), .mem_data(mem_data),
    .alu_result(alu_result), .mem2Reg_ctrl(mem2Reg_ctrl),
    .reg_dest5(reg_dest5), .reg_write_wb(reg_write_wb), .dm_err(dm_err)
  );

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu;
    logic        m2r;
    logic [4:0]  dest;
    logic        rw;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_mem [int];
  logic [31:0] resp_mem [int];
  int          checks = 0;
  int          errors = 0;
  int          retired = 0;
  int          expected_retires = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fill(input int k);
    return 32'hBAD0_0000 | 32'(k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction on the EX outputs and push its expected retire.
  task automatic drive_inst(input logic rd, input logic wr, input logic [31:0] alu,
                            input logic [31:0] wdata, input logic [4:0] dest,
                            input logic m2r, input logic rw);
    exp_t e;
    int   k;
    ex_valid      = 1'b1;
    mem_read      = rd;
    mem_write     = wr;
    alu_result_in = alu;
    store_data    = wdata;
    reg_dest4     = dest;
    mem2Reg_in    = m2r;
    reg_write_in  = rw;
    k      = int'(alu[ADDR_W-1:0]);
    e.alu  = alu;
    e.m2r  = m2r;
    e.dest = dest;
    if (wr) begin
      model_mem[k] = wdata;
      e.mem_data   = 32'd0;
      e.rw         = 1'b0;
    end else if (rd) begin
      e.mem_data = model_mem.exists(k) ? model_mem[k] : fill(k);
      e.rw       = rw;
    end else begin
      e.mem_data = 32'd0;
      e.rw       = rw;
    end
    sb.push_back(e);
    expected_retires++;
  endtask

  task automatic bubble();
    ex_valid      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_result_in = $urandom;
    store_data    = $urandom;
    reg_dest4     = 5'($urandom);
    mem2Reg_in    = 1'b0;
    reg_write_in  = 1'b0;
  endtask

  // Serve one access: ack in the (waits+1)-th ACCESS cycle, checking the
  // request stays stable every cycle.
  task automatic access(input int waits, input logic exp_we, input logic [15:0] exp_addr,
                        input logic [31:0] exp_wdata, input string tag);
    int k;
    for (int i = 0; i <= waits; i++) begin
      chk({tag, "_stall"}, 32'(stall_out), 32'd1);
      chk({tag, "_req"}, 32'(dm_req), 32'd1);
      chk({tag, "_we"}, 32'(dm_we), 32'(exp_we));
      chk({tag, "_addr"}, 32'(dm_addr), 32'(exp_addr));
      if (exp_we) chk({tag, "_wdata"}, dm_wdata, exp_wdata);
      if (i == waits) begin
        k = int'(dm_addr);
        if (dm_we) resp_mem[k] = dm_wdata;
        dm_rdata = resp_mem.exists(k) ? resp_mem[k] : fill(k);
        dm_ack   = 1'b1;
      end else begin
        dm_rdata = $urandom;
      end
      tick();
    end
    dm_ack   = 1'b0;
    dm_rdata = $urandom;
    chk({tag, "_stall_done"}, 32'(stall_out), 32'd0);
    chk({tag, "_req_done"}, 32'(dm_req), 32'd0);
  endtask

  // Scoreboard: every wb_valid pulse must match the oldest pending entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1) begin
      retired++;
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_mem_data", mem_data, mon_e.mem_data);
        chk("wb_alu_result", alu_result, mon_e.alu);
        chk("wb_mem2reg", 32'(mem2Reg_ctrl), 32'(mon_e.m2r));
        chk("wb_reg_dest5", 32'(reg_dest5), 32'(mon_e.dest));
        chk("wb_reg_write", 32'(reg_write_wb), 32'(mon_e.rw));
        $display("retire alu=%08h mem_data=%08h dest=%0d m2r=%0b rw=%0b",
                 alu_result, mem_data, reg_dest5, mem2Reg_ctrl, reg_write_wb);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = 32'd0;
    bubble();
    model_mem[16'h0040] = 32'hDEAD_BEEF;
    resp_mem[16'h0040]  = 32'hDEAD_BEEF;
    tick();
    tick();

    // Reset state.
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_we", 32'(dm_we), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_alu_result", alu_result, 32'd0);
    chk("rst_mem2reg", 32'(mem2Reg_ctrl), 32'd0);
    chk("rst_dest5", 32'(reg_dest5), 32'd0);
    chk("rst_reg_write", 32'(reg_write_wb), 32'd0);
    chk("rst_err", 32'(dm_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU pass-through, latency 1, no stall; then fields hold on the bubble.
    drive_inst(1'b0, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b1);
    tick();
    bubble();
    chk("add_stall", 32'(stall_out), 32'd0);
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("add_pulse_end", 32'(wb_valid), 32'd0);
    chk("add_hold_alu", alu_result, 32'h0000_1234);
    chk("add_hold_dest", 32'(reg_dest5), 32'd5);

    // Back-to-back ALU ops.
    tick();
    drive_inst(1'b0, 1'b0, 32'hFFFF_0001, 32'd0, 5'd31, 1'b1, 1'b0);
    tick();
    drive_inst(1'b0, 1'b0, 32'h8000_0000, 32'd0, 5'd1, 1'b0, 1'b1);
    tick();
    chk("b2b_stall", 32'(stall_out), 32'd0);
    bubble();
    tick();

    // Load 0x0040 with three wait cycles.
    drive_inst(1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd7, 1'b1, 1'b1);
    tick();
    bubble();
    access(3, 1'b0, 16'h0040, 32'd0, "ld40");

    // Store 0xAA to 0x0010, then a load from 0x0010 held during the store.
    tick();
    drive_inst(1'b0, 1'b1, 32'h0000_0010, 32'h0000_00AA, 5'd0, 1'b0, 1'b0);
    tick();
    drive_inst(1'b1, 1'b0, 32'h0000_0010, 32'd0, 5'd9, 1'b1, 1'b1);
    access(1, 1'b1, 16'h0010, 32'h0000_00AA, "st10");
    tick();
    bubble();
    access(0, 1'b0, 16'h0010, 32'd0, "ld10");

    // Both mem_read and mem_write: store wins, no register write.
    tick();
    drive_inst(1'b1, 1'b1, 32'h0000_0022, 32'h5555_AAAA, 5'd3, 1'b0, 1'b1);
    tick();
    bubble();
    access(2, 1'b1, 16'h0022, 32'h5555_AAAA, "rmw");
    tick();
    drive_inst(1'b1, 1'b0, 32'h0001_0022, 32'd0, 5'd11, 1'b1, 1'b1);
    tick();
    bubble();
    access(0, 1'b0, 16'h0022, 32'd0, "ld22");

    // dm_ack while IDLE is ignored.
    dm_ack   = 1'b1;
    dm_rdata = $urandom;
    tick();
    tick();
    dm_ack = 1'b0;
    chk("idle_ack_stall", 32'(stall_out), 32'd0);
    chk("idle_ack_req", 32'(dm_req), 32'd0);

    // Reset asserted mid-access.
    drive_inst(1'b1, 1'b0, 32'h0000_0080, 32'd0, 5'd4, 1'b1, 1'b1);
    tick();
    bubble();
    tick();
    chk("rstmid_stall_before", 32'(stall_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", 32'(dm_req), 32'd0);
    chk("rstmid_stall", 32'(stall_out), 32'd0);
    chk("rstmid_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstmid_err", 32'(dm_err), 32'd0);
    expected_retires -= sb.size();
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    drive_inst(1'b0, 1'b0, 32'hCAFE_0001, 32'd0, 5'd12, 1'b1, 1'b1);
    tick();
    bubble();
    chk("post_rst_wb_valid", 32'(wb_valid), 32'd1);
    tick();
    drive_inst(1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd13, 1'b1, 1'b1);
    tick();
    bubble();
    access(0, 1'b0, 16'h0040, 32'd0, "post_rst_ld");

`ifdef MEM_TIMEOUT_EN
    // Never-acked load: aborts after TIMEOUT ACCESS cycles, squashed retire.
    tick();
    drive_inst(1'b1, 1'b0, 32'h0000_0044, 32'd0, 5'd6, 1'b1, 1'b1);
    mon_e          = sb.pop_back();
    mon_e.rw       = 1'b0;
    mon_e.mem_data = 32'd0;
    sb.push_back(mon_e);
    tick();
    bubble();
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_stall", 32'(stall_out), 32'd1);
      chk("to_req", 32'(dm_req), 32'd1);
      tick();
    end
    chk("to_req_drop", 32'(dm_req), 32'd0);
    chk("to_stall_drop", 32'(stall_out), 32'd0);
    chk("to_err", 32'(dm_err), 32'd1);
    tick();
    tick();
    chk("to_err_sticky", 32'(dm_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("to_err_clear", 32'(dm_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // Ack exactly in the last allowed cycle: normal retire.
    drive_inst(1'b1, 1'b0, 32'h0000_0044, 32'd0, 5'd6, 1'b1, 1'b1);
    tick();
    bubble();
    access(TIMEOUT - 1, 1'b0, 16'h0044, 32'd0, "to_edge");
    chk("to_edge_err", 32'(dm_err), 32'd0);
`else
    // Without the timeout an access simply waits.
    tick();
    drive_inst(1'b1, 1'b0, 32'h0000_0010, 32'd0, 5'd14, 1'b1, 1'b1);
    tick();
    bubble();
    access(20, 1'b0, 16'h0010, 32'd0, "long_wait");
    chk("long_wait_err", 32'(dm_err), 32'd0);
`endif

    tick();
    tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    chk("retire_count", 32'(retired), 32'(expected_retires));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
